// File: rtl/find_multi_points.sv
// Raster-scan blob detector: groups binarised pixels into up to four bounding boxes
// by proximity and publishes box centres, a valid mask, a count and a drop count at frame end.
module find_multi_points #(
    parameter int unsigned DIST = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        BINARY_FLAG,
    input  logic [15:0] H_CNT,
    input  logic [15:0] V_CNT,
    output logic [15:0] o_POINTS_H0,
    output logic [15:0] o_POINTS_V0,
    output logic [15:0] o_POINTS_H1,
    output logic [15:0] o_POINTS_V1,
    output logic [15:0] o_POINTS_H2,
    output logic [15:0] o_POINTS_V2,
    output logic [15:0] o_POINTS_H3,
    output logic [15:0] o_POINTS_V3,
    output logic [15:0] o_POINTS_LIST,
    output logic [15:0] o_POINTS_NUM,
    output logic [15:0] test
);

    localparam int unsigned W     = 16;
    localparam int unsigned CW    = W + 1;
    localparam int unsigned NSLOT = 4;
    localparam int unsigned IW    = $clog2(NSLOT);

    logic             vs_d;
    logic             frame_ok;
    logic [NSLOT-1:0] valid;
    logic [W-1:0]     min_h [NSLOT];
    logic [W-1:0]     max_h [NSLOT];
    logic [W-1:0]     min_v [NSLOT];
    logic [W-1:0]     max_v [NSLOT];
    logic [W-1:0]     drop_cnt;

    logic [W-1:0]     pt_h [NSLOT];
    logic [W-1:0]     pt_v [NSLOT];
    logic [W-1:0]     pt_list;
    logic [W-1:0]     pt_num;
    logic [W-1:0]     pt_test;

    logic             frame_start;
    logic             frame_end;
    logic             accept;
    logic [NSLOT-1:0] live;
    logic [NSLOT-1:0] match;
    logic             hit;
    logic             has_free;
    logic [IW-1:0]    hit_idx;
    logic [IW-1:0]    free_idx;
    logic [CW-1:0]    h_x;
    logic [CW-1:0]    v_x;
    logic [W-1:0]     cen_h [NSLOT];
    logic [W-1:0]     cen_v [NSLOT];
    logic [W-1:0]     num;

    // frame_ok stays low after reset until VS has been seen low, so a partial frame is never reported
    assign frame_start = VGA_VS & ~vs_d;
    assign frame_end   = ~VGA_VS & vs_d & frame_ok;
    assign accept      = VGA_VS & VGA_HS & BINARY_FLAG & frame_ok;

    // Proximity match against the slot set seen by this pixel; a frame start empties it first
    always_comb begin
        live     = frame_start ? '0 : valid;
        h_x      = CW'(H_CNT);
        v_x      = CW'(V_CNT);
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            match[k] = live[k]
                     && (h_x + CW'(DIST) >= CW'(min_h[k]))
                     && (h_x <= CW'(max_h[k]) + CW'(DIST))
                     && (v_x <= CW'(max_v[k]) + CW'(DIST));
            if (match[k] && !hit) begin
                hit     = 1'b1;
                hit_idx = IW'(k);
            end
            if (!live[k] && !has_free) begin
                has_free = 1'b1;
                free_idx = IW'(k);
            end
        end
    end

    // Box centres and slot count for the frame-end snapshot
    always_comb begin
        num = '0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            cen_h[k] = valid[k] ? W'((CW'(min_h[k]) + CW'(max_h[k])) >> 1) : '0;
            cen_v[k] = valid[k] ? W'((CW'(min_v[k]) + CW'(max_v[k])) >> 1) : '0;
            num      = num + W'(valid[k]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vs_d     <= 1'b0;
            frame_ok <= 1'b0;
            valid    <= '0;
            drop_cnt <= '0;
            pt_list  <= '0;
            pt_num   <= '0;
            pt_test  <= '0;
            for (int unsigned k = 0; k < NSLOT; k++) begin
                min_h[k] <= '0;
                max_h[k] <= '0;
                min_v[k] <= '0;
                max_v[k] <= '0;
                pt_h[k]  <= '0;
                pt_v[k]  <= '0;
            end
        end else begin
            vs_d <= VGA_VS;
            if (!VGA_VS) begin
                frame_ok <= 1'b1;
            end
            if (frame_start) begin
                valid    <= '0;
                drop_cnt <= '0;
            end
            if (accept) begin
                if (hit) begin
                    if (H_CNT < min_h[hit_idx]) min_h[hit_idx] <= H_CNT;
                    if (H_CNT > max_h[hit_idx]) max_h[hit_idx] <= H_CNT;
                    if (V_CNT > max_v[hit_idx]) max_v[hit_idx] <= V_CNT;
                end else if (has_free) begin
                    valid[free_idx] <= 1'b1;
                    min_h[free_idx] <= H_CNT;
                    max_h[free_idx] <= H_CNT;
                    min_v[free_idx] <= V_CNT;
                    max_v[free_idx] <= V_CNT;
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + W'(1);
                end
            end
            if (frame_end) begin
                pt_list <= W'(valid);
                pt_num  <= num;
                pt_test <= drop_cnt;
                for (int unsigned k = 0; k < NSLOT; k++) begin
                    pt_h[k] <= cen_h[k];
                    pt_v[k] <= cen_v[k];
                end
            end
        end
    end

    assign o_POINTS_H0   = pt_h[0];
    assign o_POINTS_V0   = pt_v[0];
    assign o_POINTS_H1   = pt_h[1];
    assign o_POINTS_V1   = pt_v[1];
    assign o_POINTS_H2   = pt_h[2];
    assign o_POINTS_V2   = pt_v[2];
    assign o_POINTS_H3   = pt_h[3];
    assign o_POINTS_V3   = pt_v[3];
    assign o_POINTS_LIST = pt_list;
    assign o_POINTS_NUM  = pt_num;
    assign test          = pt_test;

endmodule

// File: tb/tb_find_multi_points.sv
// Bench for find_multi_points: directed frames, a whole-frame reference model and per-cycle output compare.
module tb_find_multi_points;

    localparam int DIST = 4;
    localparam int HW   = 200;
    localparam int VH   = 100;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        BINARY_FLAG;
    logic [15:0] H_CNT;
    logic [15:0] V_CNT;
    logic [15:0] o_POINTS_H0, o_POINTS_V0, o_POINTS_H1, o_POINTS_V1;
    logic [15:0] o_POINTS_H2, o_POINTS_V2, o_POINTS_H3, o_POINTS_V3;
    logic [15:0] o_POINTS_LIST, o_POINTS_NUM, test;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int exp_h [4];
    int exp_v [4];
    int exp_list, exp_num, exp_test;
    bit bm [0:VH-1][0:HW-1];

    find_multi_points #(.DIST(DIST)) dut (
        .CLK(CLK), .RST(RST), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .BINARY_FLAG(BINARY_FLAG), .H_CNT(H_CNT), .V_CNT(V_CNT),
        .o_POINTS_H0(o_POINTS_H0), .o_POINTS_V0(o_POINTS_V0),
        .o_POINTS_H1(o_POINTS_H1), .o_POINTS_V1(o_POINTS_V1),
        .o_POINTS_H2(o_POINTS_H2), .o_POINTS_V2(o_POINTS_V2),
        .o_POINTS_H3(o_POINTS_H3), .o_POINTS_V3(o_POINTS_V3),
        .o_POINTS_LIST(o_POINTS_LIST), .o_POINTS_NUM(o_POINTS_NUM), .test(test)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("h0", int'(o_POINTS_H0), exp_h[0]);
            chk("v0", int'(o_POINTS_V0), exp_v[0]);
            chk("h1", int'(o_POINTS_H1), exp_h[1]);
            chk("v1", int'(o_POINTS_V1), exp_v[1]);
            chk("h2", int'(o_POINTS_H2), exp_h[2]);
            chk("v2", int'(o_POINTS_V2), exp_v[2]);
            chk("h3", int'(o_POINTS_H3), exp_h[3]);
            chk("v3", int'(o_POINTS_V3), exp_v[3]);
            chk("list", int'(o_POINTS_LIST), exp_list);
            chk("num", int'(o_POINTS_NUM), exp_num);
            chk("test", int'(test), exp_test);
        end
    end

    task automatic set_exp_zero();
        for (int k = 0; k < 4; k++) begin
            exp_h[k] = 0;
            exp_v[k] = 0;
        end
        exp_list = 0;
        exp_num  = 0;
        exp_test = 0;
    endtask

    // Reference: walk the frame bitmap in raster order and apply the grouping rules with plain ints
    task automatic compute_model();
        int  mnh [4];
        int  mxh [4];
        int  mnv [4];
        int  mxv [4];
        bit  val [4];
        int  drops;
        int  sel;
        drops = 0;
        for (int k = 0; k < 4; k++) begin
            val[k] = 1'b0; mnh[k] = 0; mxh[k] = 0; mnv[k] = 0; mxv[k] = 0;
        end
        for (int v = 0; v < VH; v++) begin
            for (int h = 0; h < HW; h++) begin
                if (bm[v][h]) begin
                    sel = -1;
                    for (int k = 3; k >= 0; k--)
                        if (val[k] && h + DIST >= mnh[k] && h <= mxh[k] + DIST && v <= mxv[k] + DIST)
                            sel = k;
                    if (sel >= 0) begin
                        if (h < mnh[sel]) mnh[sel] = h;
                        if (h > mxh[sel]) mxh[sel] = h;
                        if (v > mxv[sel]) mxv[sel] = v;
                    end else begin
                        for (int k = 3; k >= 0; k--)
                            if (!val[k]) sel = k;
                        if (sel >= 0) begin
                            val[sel] = 1'b1;
                            mnh[sel] = h; mxh[sel] = h; mnv[sel] = v; mxv[sel] = v;
                        end else if (drops < 65535) begin
                            drops++;
                        end
                    end
                end
            end
        end
        exp_list = 0;
        exp_num  = 0;
        for (int k = 0; k < 4; k++) begin
            exp_h[k] = val[k] ? (mnh[k] + mxh[k]) / 2 : 0;
            exp_v[k] = val[k] ? (mnv[k] + mxv[k]) / 2 : 0;
            if (val[k]) begin
                exp_list += (1 << k);
                exp_num++;
            end
        end
        exp_test = drops;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_bm();
        for (int v = 0; v < VH; v++)
            for (int h = 0; h < HW; h++)
                bm[v][h] = 1'b0;
    endtask

    task automatic add_rect(input int x0, input int x1, input int y0, input int y1);
        for (int v = y0; v <= y1; v++)
            for (int h = x0; h <= x1; h++)
                bm[v][h] = 1'b1;
    endtask

    function automatic bit row_any(input int v);
        for (int h = 0; h < HW; h++)
            if (bm[v][h]) return 1'b1;
        return 1'b0;
    endfunction

    // One active line followed by a blanking cycle carrying a stray flag that must be ignored
    task automatic drive_row(input int v);
        for (int h = 0; h < HW; h++) begin
            VGA_HS = 1'b1;
            H_CNT = 16'(h);
            V_CNT = 16'(v);
            BINARY_FLAG = bm[v][h];
            step();
        end
        VGA_HS = 1'b0;
        BINARY_FLAG = 1'b1;
        H_CNT = 16'(5);
        V_CNT = 16'(v);
        step();
        BINARY_FLAG = 1'b0;
    endtask

    // Inter-frame idle with the flag high while VS is low
    task automatic idle_gap();
        for (int i = 0; i < 3; i++) begin
            VGA_HS = 1'b1;
            BINARY_FLAG = 1'b1;
            H_CNT = 16'(3);
            V_CNT = 16'(3);
            step();
        end
        VGA_HS = 1'b0;
        BINARY_FLAG = 1'b0;
        step();
    endtask

    // full: drive every line; tight: first pixel arrives on the same cycle VS rises
    task automatic drive_frame(input bit full, input bit tight);
        VGA_VS = 1'b1;
        VGA_HS = 1'b0;
        BINARY_FLAG = 1'b0;
        if (!tight) step();
        for (int v = 0; v < VH; v++)
            if (full || row_any(v)) drive_row(v);
        VGA_VS = 1'b0;
        VGA_HS = 1'b0;
        BINARY_FLAG = 1'b0;
        step();
        compute_model();
        idle_gap();
    endtask

    initial begin
        RST = 1'b1;
        VGA_HS = 1'b0;
        VGA_VS = 1'b0;
        BINARY_FLAG = 1'b0;
        H_CNT = '0;
        V_CNT = '0;
        set_exp_zero();
        clear_bm();
        step(); step(); step();
        cmp_en = 1'b1;
        chk("rst_num", int'(o_POINTS_NUM), 0);
        chk("rst_test", int'(test), 0);
        RST = 1'b0;
        step(); step();

        // empty 200x100 frame
        drive_frame(1'b1, 1'b0);
        chk("empty_num", int'(o_POINTS_NUM), 0);
        chk("empty_list", int'(o_POINTS_LIST), 0);

        // single 3x3 blob, twice
        add_rect(50, 52, 20, 22);
        for (int r = 0; r < 2; r++) begin
            drive_frame(1'b0, 1'b0);
            chk("blob_h0", int'(o_POINTS_H0), 51);
            chk("blob_v0", int'(o_POINTS_V0), 21);
            chk("blob_num", int'(o_POINTS_NUM), 1);
            chk("blob_list", int'(o_POINTS_LIST), 1);
        end

        // four separated blobs
        clear_bm();
        add_rect(10, 12, 5, 7);
        add_rect(100, 104, 5, 9);
        add_rect(30, 30, 50, 50);
        add_rect(150, 160, 80, 90);
        drive_frame(1'b0, 1'b0);
        chk("four_h1", int'(o_POINTS_H1), 102);
        chk("four_v1", int'(o_POINTS_V1), 7);
        chk("four_h2", int'(o_POINTS_H2), 30);
        chk("four_v3", int'(o_POINTS_V3), 85);
        chk("four_list", int'(o_POINTS_LIST), 15);

        // fifth blob is dropped
        add_rect(190, 191, 95, 96);
        drive_frame(1'b0, 1'b0);
        chk("five_test", int'(test), 4);
        chk("five_h3", int'(o_POINTS_H3), 155);
        chk("five_num", int'(o_POINTS_NUM), 4);

        // pixel coincident with frame start must see an empty slot set
        clear_bm();
        bm[3][0] = 1'b1;
        bm[3][2] = 1'b1;
        drive_frame(1'b0, 1'b1);
        chk("tight_h0", int'(o_POINTS_H0), 1);
        chk("tight_v0", int'(o_POINTS_V0), 3);
        chk("tight_num", int'(o_POINTS_NUM), 1);
        chk("tight_test", int'(test), 0);

        // within DIST: one slot
        clear_bm();
        bm[10][40] = 1'b1;
        bm[12][43] = 1'b1;
        drive_frame(1'b0, 1'b0);
        chk("near_h0", int'(o_POINTS_H0), 41);
        chk("near_v0", int'(o_POINTS_V0), 11);
        chk("near_num", int'(o_POINTS_NUM), 1);

        // just beyond DIST: two slots
        clear_bm();
        bm[10][40] = 1'b1;
        bm[10][45] = 1'b1;
        drive_frame(1'b0, 1'b0);
        chk("far_num", int'(o_POINTS_NUM), 2);
        chk("far_list", int'(o_POINTS_LIST), 3);
        chk("far_h1", int'(o_POINTS_H1), 45);

        // reset mid-frame: outputs clear and the partial frame is never reported
        clear_bm();
        add_rect(50, 52, 20, 22);
        VGA_VS = 1'b1;
        step();
        drive_row(20);
        RST = 1'b1;
        step();
        set_exp_zero();
        step();
        RST = 1'b0;
        drive_row(21);
        drive_row(22);
        VGA_VS = 1'b0;
        step();
        idle_gap();
        chk("rstmid_num", int'(o_POINTS_NUM), 0);
        chk("rstmid_h1", int'(o_POINTS_H1), 0);

        // next complete frame reports normally
        drive_frame(1'b0, 1'b0);
        chk("post_h0", int'(o_POINTS_H0), 51);
        chk("post_num", int'(o_POINTS_NUM), 1);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/find_multi_points.md
Name: find_multi_points

Overview:
- Raster-scan blob detector for a binarised camera/VGA stream.
- Each pixel with BINARY_FLAG=1 is grouped into one of up to 4 bounding-box slots by proximity.
- At end of frame it publishes each slot's box centre, a valid-slot mask, the slot count and an overflow counter.
- Sits after the binarisation stage and feeds the point-tracking and overlay logic.

Parameters:
- DIST, 4: merge distance in pixels; a pixel within DIST of a slot's box (H either side, V below) joins that slot.

Ports:
- CLK  in  1  pixel clock; one pixel per rising edge.
- RST  in  1  synchronous, active-high reset.
- VGA_HS  in  1  line-active qualifier; pixels are valid only while high.
- VGA_VS  in  1  frame-active qualifier; rising edge = frame start, falling edge = frame end.
- BINARY_FLAG  in  1  binarised pixel value for the current (H_CNT, V_CNT).
- H_CNT  in  16  pixel x coordinate.
- V_CNT  in  16  pixel y coordinate.
- o_POINTS_H0/V0 .. o_POINTS_H3/V3  out  16 each  centre x/y of slots 0..3; 0 if the slot is invalid.
- o_POINTS_LIST  out  16  bit k = slot k valid; bits 15:4 = 0.
- o_POINTS_NUM  out  16  number of valid slots, 0..4.
- test  out  16  dropped-pixel count of the last frame, saturating.

Behaviour:
- One clock domain (CLK), synchronous active-high reset; all state updates on CLK rising edge.
- Reset: all outputs = 0; working slots invalid; previous-VS register = 0; drop counter = 0.
- Reset mid-frame: the partial frame is discarded; outputs stay 0 until the next complete frame end.
- Edge detection: VS_d is VGA_VS registered.
  - Frame start (VGA_VS=1, VS_d=0): invalidate all working slots, clear the drop counter.
- Pixel accept: on a rising edge with VGA_VS=1, VGA_HS=1 and BINARY_FLAG=1, take pixel (h,v)=(H_CNT,V_CNT).
- Match test for a valid slot k with box minH/maxH/minV/maxV:
  - h+DIST >= minH
  - h <= maxH+DIST
  - v <= maxV+DIST
  - Compute all comparisons in 17 bits; no underflow or overflow.
- Pixel handling:
  - If any slot matches, the lowest-index match wins: minH = min(minH,h), maxH = max(maxH,h), maxV = max(maxV,v). minV is unchanged because scanning is raster order.
  - Otherwise, if a slot is free, the lowest-index free slot becomes valid with minH=maxH=h and minV=maxV=v.
  - Otherwise the pixel is dropped and the drop counter increments, saturating at 0xFFFF.
- Box updates are visible to the very next pixel; no pipeline bubbles; one pixel per clock sustained.
- Slots never merge with each other; a pixel touching two slots extends only the lower-index one.
- Slots are numbered in order of first raster appearance.
- Frame end (VGA_VS=0, VS_d=1): latch outputs in the same cycle; they are visible one cycle after the falling edge.
  - Valid slot k: H = (minH+maxH)>>1, V = (minV+maxV)>>1, using 17-bit sums truncated to 16 bits.
  - Invalid slot: H = V = 0.
  - o_POINTS_LIST = valid mask; o_POINTS_NUM = popcount of the mask; test = drop counter.
- Outputs hold their values until the next frame end or reset.
- VGA_HS low, or VGA_VS low: BINARY_FLAG is ignored.
- Simultaneous frame start and accepted pixel:
  - The clear takes priority for stale slots.
  - The pixel is evaluated against an empty slot set, so it allocates slot 0.
- Empty frame: NUM=0, LIST=0, all coordinates 0, test=0.

Test Plan:
- Frame 200x100 all zero -> at frame end NUM=0, LIST=0x0000, all H/V=0, test=0.
- Single 3x3 blob at x 50..52, y 20..22 -> H0=51, V0=21, NUM=1, LIST=0x0001, test=0; a repeated identical frame gives identical outputs, stable between frame ends.
- Four blobs separated by more than DIST:
  - Blobs: x10..12,y5..7; x100..104,y5..9; x30..30,y50..50; x150..160,y80..90.
  - Expected: (11,6), (102,7), (30,50), (155,85); NUM=4, LIST=0x000F.
- Fifth blob 2x2 at x190..191, y95..96 added to the above -> slots unchanged, test=4.
- Two pixels (40,10) and (43,12) with DIST=4 -> one slot, H0=41, V0=11, NUM=1; pixels at (40,10) and (45,10) -> two slots.
- Flag=1 while VGA_HS=0 -> ignored; RST asserted mid-frame -> all outputs 0; next full frame reports normally.
